mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter sharing one single-ported memory between the CPU's instruction-fetch port and data port. It latches one request at a time, drives the shared memory bus until the memory reports completion, then returns a one-cycle ready pulse with registered read data to the owning requester. It sits between `cpu_top`'s `imem_*`/`dmem_*` ports and the unified memory or cache.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width. Byte enable is `DATA_WIDTH/8` bits.
- `MAX_DATA_STREAK`, 4: consecutive data grants allowed while a fetch waits. Used only with `ARB_FAIRNESS_EN`. Must be ≥1.

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_addr` in `ADDR_WIDTH`: fetch address.
- `imem_read` in 1: fetch request.
- `imem_read_data` out `DATA_WIDTH`: fetched word.
- `imem_ready` out 1: fetch completion pulse.
- `dmem_addr` in `ADDR_WIDTH`: data address.
- `dmem_write_data` in `DATA_WIDTH`: store data.
- `dmem_read` in 1: load request.
- `dmem_write` in 1: store request.
- `dmem_byte_enable` in `DATA_WIDTH/8`: store byte lanes.
- `dmem_read_data` out `DATA_WIDTH`: load data.
- `dmem_ready` out 1: data completion pulse.
- `mem_addr` out `ADDR_WIDTH`: shared bus address.
- `mem_write_data` out `DATA_WIDTH`: shared bus write data.
- `mem_read` out 1: shared bus read strobe.
- `mem_write` out 1: shared bus write strobe.
- `mem_byte_enable` out `DATA_WIDTH/8`: shared bus byte lanes.
- `mem_read_data` in `DATA_WIDTH`: memory read data.
- `mem_ready` in 1: memory completion, qualified by an active strobe.
- `arb_owner` out 2: 00 none, 01 fetch, 10 data.
- `arb_busy` out 1: state ≠ IDLE.

## Operation
States and transitions:
- **IDLE**: evaluate requests.
  - If a winner exists: latch its address, data, byte-enable and direction into the `mem_*` registers, set `arb_owner`, go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**: hold every `mem_*` output stable.
  - When `mem_ready=1`: capture `mem_read_data`, clear `mem_read`/`mem_write`, go to RESP.
- **RESP**: assert the owner's ready for exactly one cycle. The read data register is valid on the owner's `*_read_data` in this cycle. Return to IDLE and set `arb_owner`=00.

Priority:
- Default: data beats fetch.
- Fetch reads always use `mem_byte_enable`=all ones and `mem_write`=0.

Request and protocol rules:
- `dmem_read` and `dmem_write` both high: treat as a write; the read is ignored.
- A requester holds its request until its ready pulse. A request still high in the cycle after RESP is a new request.
- A request dropped or changed during BUSY does not abort the transaction. The latched values are used, and the ready pulse still fires.
- `mem_ready` outside BUSY is ignored.
- `*_read_data` outputs hold their last captured value. After a write, `dmem_read_data` is unchanged.

Reset:
- All outputs are 0. State is IDLE and the streak counter is 0.
- Reset in BUSY abandons the transaction immediately. No ready pulse is generated.

## Timing
- Request sampled in IDLE at cycle N → `mem_read`/`mem_write` high from N+1.
- `mem_ready` in cycle M ≥ N+1 → requester ready in M+1. Minimum round trip is 2 cycles, i.e. ready at N+2.
- Back-to-back throughput: one transaction per (memory latency + 2) cycles. IDLE always occupies one cycle between transactions.
- All outputs are registered. There are no combinational paths from `mem_*` inputs to requester outputs.

## Configuration
- `ARB_FAIRNESS_EN` defined:
  - A streak counter (`$clog2(MAX_DATA_STREAK+1)` bits) increments on each data grant made while `imem_read` is pending.
  - It clears on any fetch grant, or on an IDLE cycle with no fetch pending.
  - When the counter equals `MAX_DATA_STREAK` and both ports request, fetch wins. The counter saturates and never wraps.
- `ARB_FAIRNESS_EN` undefined: strict data priority, and no counter is synthesised.

## Structure
- Shared package `mem_arb_pkg`:
  - `arb_state_t` (IDLE, BUSY, RESP).
  - `arb_owner_t` (OWN_NONE=2'b00, OWN_FETCH=2'b01, OWN_DATA=2'b10).
- One sub-module, `mem_arb_grant`: combinational winner selection plus the streak counter register, which exists only under `ARB_FAIRNESS_EN`.
- The top of the block holds the FSM and the bus/response registers.

## Test plan
1. Fetch only, `imem_addr`=0x100, memory ready 1 cycle after strobe (one-cycle wait, 3-cycle round trip) → `mem_read` high 2 cycles with `mem_addr`=0x100, `imem_ready` pulses at N+3, `imem_read_data`=memory word, `arb_owner` 01→00.
2. Fetch 0x200 and load 0x8000 in the same cycle → data served first (`mem_addr`=0x8000, `dmem_ready` then `dmem_read_data` valid), then fetch 0x200.
3. Store 0xDEADBEEF, byte enable 4'b0011, `dmem_read` also high → `mem_write`=1, `mem_read`=0, byte enable 0011, `dmem_read_data` unchanged.
4. With `ARB_FAIRNESS_EN` and `MAX_DATA_STREAK`=4, fetch and data held continuously → grant order D,D,D,D,F,D…; without the macro → data only, fetch starves.
5. Assert `rst_n`=0 during BUSY with `mem_ready` still low → all outputs 0 immediately; after release, no ready pulse occurs and state is IDLE.
6. `dmem_addr` changed from 0x10 to 0x20 during BUSY → `mem_addr` stays 0x10 until RESP.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the fetch/data memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'b00,
    OWN_FETCH = 2'b01,
    OWN_DATA  = 2'b10
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - winner selection; data-streak fairness counter under ARB_FAIRNESS_EN
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
`ifdef ARB_FAIRNESS_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic grant_en,
  input  logic fetch_req,
  input  logic data_req,
  output logic grant_fetch,
  output logic grant_data
);

  if (MAX_DATA_STREAK < 1) begin : g_streak_check
    $error("MAX_DATA_STREAK must be at least 1");
  end

`ifdef ARB_FAIRNESS_EN
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                fetch_turn;

  assign fetch_turn = (streak_q == STREAK_MAX);

  // Data wins unless the fetch port has waited out a full streak of data grants.
  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (grant_en) begin
      if (data_req && !(fetch_req && fetch_turn)) begin
        grant_data = 1'b1;
      end else if (fetch_req) begin
        grant_fetch = 1'b1;
      end
    end
  end

  // Count data grants that bypassed a waiting fetch; saturates at the limit.
  always_comb begin
    streak_d = streak_q;
    if (grant_en) begin
      if (grant_fetch || !fetch_req) begin
        streak_d = '0;
      end else if (grant_data && !fetch_turn) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end
  end

  // Streak counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  // Strict data priority.
  always_comb begin
    grant_data  = grant_en && data_req;
    grant_fetch = grant_en && fetch_req && !data_req;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-ported memory (option: ARB_FAIRNESS_EN)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   imem_addr,
  input  logic                    imem_read,
  output logic [DATA_WIDTH-1:0]   imem_read_data,
  output logic                    imem_ready,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_write_data,
  input  logic                    dmem_read,
  input  logic                    dmem_write,
  input  logic [DATA_WIDTH/8-1:0] dmem_byte_enable,
  output logic [DATA_WIDTH-1:0]   dmem_read_data,
  output logic                    dmem_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  input  logic                    mem_ready,
  output logic [1:0]              arb_owner,
  output logic                    arb_busy
);

  arb_state_t                state_q, state_d;
  arb_owner_t                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic                      mem_read_q, mem_read_d;
  logic                      mem_write_q, mem_write_d;
  logic [DATA_WIDTH/8-1:0]   mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0]     imem_rdata_q, imem_rdata_d;
  logic [DATA_WIDTH-1:0]     dmem_rdata_q, dmem_rdata_d;
  logic                      imem_ready_q, imem_ready_d;
  logic                      dmem_ready_q, dmem_ready_d;
  logic                      busy_q, busy_d;
  logic                      grant_fetch, grant_data;

  mem_arb_grant #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_grant (
`ifdef ARB_FAIRNESS_EN
    .clk        (clk),
    .rst_n      (rst_n),
`endif
    .grant_en   (state_q == IDLE),
    .fetch_req  (imem_read),
    .data_req   (dmem_read | dmem_write),
    .grant_fetch(grant_fetch),
    .grant_data (grant_data)
  );

  // Next state: latch the winner in IDLE, wait for memory in BUSY, pulse ready in RESP.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_be_d     = mem_be_q;
    imem_rdata_d = imem_rdata_q;
    dmem_rdata_d = dmem_rdata_q;
    imem_ready_d = 1'b0;
    dmem_ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          mem_addr_d  = dmem_addr;
          mem_wdata_d = dmem_write_data;
          mem_be_d    = dmem_byte_enable;
          mem_write_d = dmem_write;
          mem_read_d  = ~dmem_write;
          owner_d     = OWN_DATA;
          state_d     = BUSY;
        end else if (grant_fetch) begin
          mem_addr_d  = imem_addr;
          mem_be_d    = '1;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          owner_d     = OWN_FETCH;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          if (owner_q == OWN_FETCH) begin
            imem_rdata_d = mem_read_data;
            imem_ready_d = 1'b1;
          end else begin
            // A store leaves the load-data register untouched.
            if (mem_read_q) begin
              dmem_rdata_d = mem_read_data;
            end
            dmem_ready_d = 1'b1;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
      default: begin
        owner_d     = OWN_NONE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, bus and response registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_be_q     <= '0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
      imem_ready_q <= 1'b0;
      dmem_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_be_q     <= mem_be_d;
      imem_rdata_q <= imem_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
      imem_ready_q <= imem_ready_d;
      dmem_ready_q <= dmem_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign imem_read_data  = imem_rdata_q;
  assign imem_ready      = imem_ready_q;
  assign dmem_read_data  = dmem_rdata_q;
  assign dmem_ready      = dmem_ready_q;
  assign mem_addr        = mem_addr_q;
  assign mem_write_data  = mem_wdata_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_enable = mem_be_q;
  assign arb_owner       = owner_q;
  assign arb_busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam logic [1:0] O_NONE = 2'b00;
  localparam logic [1:0] O_F    = 2'b01;
  localparam logic [1:0] O_D    = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr = '0;
  logic        imem_read = 1'b0;
  logic [31:0] imem_read_data;
  logic        imem_ready;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_write_data = '0;
  logic        dmem_read = 1'b0;
  logic        dmem_write = 1'b0;
  logic [3:0]  dmem_byte_enable = '0;
  logic [31:0] dmem_read_data;
  logic        dmem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic [1:0]  arb_owner;
  logic        arb_busy;

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_read(imem_read),
    .imem_read_data(imem_read_data), .imem_ready(imem_ready),
    .dmem_addr(dmem_addr), .dmem_write_data(dmem_write_data),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_byte_enable(dmem_byte_enable),
    .dmem_read_data(dmem_read_data), .dmem_ready(dmem_ready),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .arb_owner(arb_owner), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          lat_cfg = 0;
  bit          poke = 1'b0;
  int          streak = 0;
  logic [31:0] last_iread = '0;
  logic [31:0] last_dread = '0;
  logic [31:0] mem_store [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hA5A5_5A5A;
  endfunction

  // Memory emulation: answers an active strobe after lat_cfg wait cycles.
  initial begin : responder
    int          wait_cnt;
    logic [31:0] cur;
    wait_cnt = 0;
    mem_ready = 1'b0;
    mem_read_data = '0;
    forever begin
      @(negedge clk);
      if ((mem_read || mem_write) && !mem_ready) begin
        if (wait_cnt >= lat_cfg) begin
          mem_ready = 1'b1;
          cur = mem_store.exists(mem_addr) ? mem_store[mem_addr] : word_of(mem_addr);
          if (mem_write) begin
            for (int b = 0; b < 4; b++)
              if (mem_byte_enable[b]) cur[8*b +: 8] = mem_write_data[8*b +: 8];
            mem_store[mem_addr] = cur;
            mem_read_data = $urandom;
          end else begin
            mem_read_data = cur;
          end
        end else begin
          wait_cnt++;
          mem_read_data = $urandom;
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt = 0;
        mem_read_data = $urandom;
      end
      if (poke) mem_ready = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pick(input bit f, input bit d);
    if (d && !(f && FAIR && streak >= MAXS)) return O_D;
    if (f) return O_F;
    return O_NONE;
  endfunction

  // Follow one transaction from grant to the following IDLE cycle.
  task automatic serve(input logic [1:0] own, input int lat, input bit keep, input bit perturb);
    logic [31:0] addr, wd, exp_rd, old;
    logic [3:0]  be;
    bit          wr, fpend, ok;
    int          cnt;
    fpend = imem_read;
    if (own == O_F) begin
      addr = imem_addr; wr = 1'b0; be = 4'hF; wd = '0;
    end else begin
      addr = dmem_addr; wr = dmem_write; be = dmem_byte_enable; wd = dmem_write_data;
    end
    if (own == O_F) streak = 0;
    else if (fpend) streak = (streak < MAXS) ? streak + 1 : MAXS;
    else streak = 0;
    lat_cfg = lat;
    @(negedge clk);
    chk("grant_owner", arb_owner, own);
    chk("grant_busy", arb_busy, 1'b1);
    chk("grant_addr", mem_addr, addr);
    chk("grant_strobes", {mem_read, mem_write}, {!wr, wr});
    chk("grant_be", mem_byte_enable, be);
    if (wr) chk("grant_wdata", mem_write_data, wd);
    if (perturb) begin
      dmem_addr = dmem_addr ^ 32'h30;
      dmem_write_data = $urandom;
      dmem_read = 1'b0;
      dmem_write = 1'b0;
    end
    ok = 1'b0;
    cnt = 0;
    for (int i = 0; i < lat + 8; i++) begin
      @(negedge clk);
      cnt++;
      if (imem_ready || dmem_ready) begin
        ok = 1'b1;
        break;
      end
      chk("busy_addr_hold", mem_addr, addr);
      chk("busy_strobe_hold", {mem_read, mem_write}, {!wr, wr});
    end
    chk("ready_seen", ok, 1'b1);
    chk("round_trip", cnt, lat + 1);
    chk("ready_port", {imem_ready, dmem_ready}, (own == O_F) ? 2'b10 : 2'b01);
    exp_rd = ref_mem.exists(addr) ? ref_mem[addr] : word_of(addr);
    if (own == O_F) begin
      chk("imem_rdata", imem_read_data, exp_rd);
      last_iread = exp_rd;
    end else if (wr) begin
      old = exp_rd;
      for (int b = 0; b < 4; b++)
        if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
      ref_mem[addr] = old;
    end else begin
      chk("dmem_rdata", dmem_read_data, exp_rd);
      last_dread = exp_rd;
    end
    chk("dmem_rdata_hold", dmem_read_data, last_dread);
    chk("imem_rdata_hold", imem_read_data, last_iread);
    chk("resp_strobes_clear", {mem_read, mem_write}, 2'b00);
    chk("resp_owner", arb_owner, own);
    if (!keep) begin
      if (own == O_F) imem_read = 1'b0;
      else begin
        dmem_read = 1'b0;
        dmem_write = 1'b0;
      end
    end
    @(negedge clk);
    chk("single_cycle_ready", {imem_ready, dmem_ready}, 2'b00);
    chk("idle_owner", arb_owner, O_NONE);
    chk("idle_busy", arb_busy, 1'b0);
  endtask

  initial begin : main
    logic [31:0] w;
    int          kind, guard;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {imem_ready, dmem_ready, mem_read, mem_write, arb_busy, arb_owner, mem_byte_enable}, '0);
    chk("reset_mem_addr", mem_addr, '0);
    chk("reset_mem_wdata", mem_write_data, '0);
    chk("reset_rdata", {imem_read_data, dmem_read_data}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch only, one memory wait cycle.
    imem_addr = 32'h100; imem_read = 1'b1;
    serve(pick(1'b1, 1'b0), 1, 1'b0, 1'b0);

    // Simultaneous fetch and load: data first, then fetch.
    imem_addr = 32'h200; imem_read = 1'b1;
    dmem_addr = 32'h8000; dmem_read = 1'b1;
    chk("prio_model", pick(1'b1, 1'b1), O_D);
    serve(pick(1'b1, 1'b1), 2, 1'b0, 1'b0);
    serve(pick(imem_read, dmem_read | dmem_write), 0, 1'b0, 1'b0);

    // Store with read also high behaves as a write.
    dmem_addr = 32'h1000; dmem_read = 1'b1;
    serve(O_D, 1, 1'b0, 1'b0);
    dmem_addr = 32'h1000; dmem_write_data = 32'hDEADBEEF;
    dmem_byte_enable = 4'b0011; dmem_read = 1'b1; dmem_write = 1'b1;
    serve(pick(1'b0, 1'b1), 2, 1'b0, 1'b0);
    dmem_addr = 32'h1000; dmem_read = 1'b1; dmem_byte_enable = 4'b0000;
    serve(O_D, 0, 1'b0, 1'b0);
    w = word_of(32'h1000);
    chk("store_merge", dmem_read_data, {w[31:16], 16'hBEEF});

    // Address change during BUSY must not disturb the latched transaction.
    dmem_addr = 32'h10; dmem_read = 1'b1;
    serve(O_D, 3, 1'b0, 1'b1);

    // mem_ready while idle is ignored.
    @(posedge clk);
    #1 poke = 1'b1;
    @(negedge clk);
    #1 poke = 1'b0;
    @(negedge clk);
    chk("stray_ready", {imem_ready, dmem_ready, arb_busy, mem_read, mem_write}, '0);
    @(negedge clk);
    chk("stray_ready_late", {imem_ready, dmem_ready, arb_busy}, '0);

    // Continuous contention: fairness order or data starvation.
    streak = 0;
    imem_addr = 32'h300; imem_read = 1'b1;
    dmem_addr = 32'h400; dmem_read = 1'b1;
    for (int g = 0; g < 10; g++) serve(pick(1'b1, 1'b1), 0, 1'b1, 1'b0);
    imem_read = 1'b0; dmem_read = 1'b0;
    @(negedge clk);
    streak = 0;

    // Reset during BUSY abandons the transaction.
    dmem_addr = 32'h40; dmem_read = 1'b1; lat_cfg = 20;
    @(negedge clk);
    chk("rst_pre_busy", arb_busy, 1'b1);
    #2 rst_n = 1'b0;
    dmem_read = 1'b0;
    #1;
    chk("rst_async_ctrl", {imem_ready, dmem_ready, mem_read, mem_write, arb_busy, arb_owner, mem_byte_enable}, '0);
    chk("rst_async_addr", {mem_addr, mem_write_data}, '0);
    chk("rst_async_rdata", {imem_read_data, dmem_read_data}, '0);
    last_iread = '0;
    last_dread = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {imem_ready, dmem_ready, arb_busy, arb_owner, mem_read, mem_write}, '0);
    end
    streak = 0;

    // Randomized traffic against the reference model.
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 3);
      imem_read = $urandom_range(0, 1);
      imem_addr = 32'h2000 + {$urandom_range(0, 15), 2'b00};
      dmem_addr = 32'h1000 + {$urandom_range(0, 15), 2'b00};
      dmem_write_data = $urandom;
      dmem_byte_enable = 4'($urandom);
      dmem_read = (kind == 1) || (kind == 3);
      dmem_write = (kind >= 2);
      if (!imem_read && !dmem_read && !dmem_write) imem_read = 1'b1;
      guard = 0;
      while ((imem_read || dmem_read || dmem_write) && guard < 3) begin
        serve(pick(imem_read, dmem_read | dmem_write), $urandom_range(0, 3), 1'b0, 1'b0);
        guard++;
      end
      chk("rand_drained", {imem_read, dmem_read, dmem_write}, 3'b000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
